// File: rtl/telemetry_frame_rx.sv
// Telemetry frame receiver: SYNC,TGT,X,Y,Z,T,CHK -> checked coordinate record.
// Latency 1 cycle from CHK accept to out_valid; in_ready drops while a record is held.
module telemetry_frame_rx #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_TGT = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] out_target,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [7:0] out_z,
  output logic [7:0] out_t,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_chksum,
  output logic       err_target,
  output logic [7:0] frame_count
);

  localparam logic [7:0] MAX_B = 8'(MAX_TGT);

  typedef enum logic [2:0] {IDLE, TGT, X, Y, Z, T, CHK, HOLD} state_t;

  state_t     state;
  logic [7:0] xsum;
  logic [7:0] tgt_q, x_q, y_q, z_q, t_q;
  logic       acc;

  assign in_ready = ~rst & (state != HOLD);
  assign acc      = in_valid & in_ready;

  // Fields are staged in *_q and only copied to out_* once the checksum matches,
  // so a bad frame never disturbs the previously presented record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      xsum        <= 8'h00;
      tgt_q       <= 8'h00;
      x_q         <= 8'h00;
      y_q         <= 8'h00;
      z_q         <= 8'h00;
      t_q         <= 8'h00;
      out_target  <= 5'd0;
      out_x       <= 8'h00;
      out_y       <= 8'h00;
      out_z       <= 8'h00;
      out_t       <= 8'h00;
      out_valid   <= 1'b0;
      err_chksum  <= 1'b0;
      err_target  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      err_chksum <= 1'b0;
      err_target <= 1'b0;
      case (state)
        IDLE: if (acc && in_data == SYNC) begin
          xsum  <= 8'h00;
          state <= TGT;
        end
        TGT: if (acc) begin
          if (in_data > MAX_B) begin
            err_target <= 1'b1;
            state      <= IDLE;
          end else begin
            tgt_q <= in_data;
            xsum  <= xsum ^ in_data;
            state <= X;
          end
        end
        X: if (acc) begin
          x_q   <= in_data;
          xsum  <= xsum ^ in_data;
          state <= Y;
        end
        Y: if (acc) begin
          y_q   <= in_data;
          xsum  <= xsum ^ in_data;
          state <= Z;
        end
        Z: if (acc) begin
          z_q   <= in_data;
          xsum  <= xsum ^ in_data;
          state <= T;
        end
        T: if (acc) begin
          t_q   <= in_data;
          xsum  <= xsum ^ in_data;
          state <= CHK;
        end
        CHK: if (acc) begin
          if (in_data == xsum) begin
            out_target <= tgt_q[4:0];
            out_x      <= x_q;
            out_y      <= y_q;
            out_z      <= z_q;
            out_t      <= t_q;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            err_chksum <= 1'b1;
            state      <= IDLE;
          end
        end
        HOLD: if (out_ready) begin
          out_valid   <= 1'b0;
          frame_count <= frame_count + 8'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry_frame_rx.sv
// Cycle-by-cycle check of telemetry_frame_rx against a frame-level reference model.
module tb_telemetry_frame_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] out_target;
  logic [7:0] out_x, out_y, out_z, out_t;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err_chksum, err_target;
  logic [7:0] frame_count;

  int total = 0;
  int bad   = 0;

  telemetry_frame_rx dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_target(out_target), .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_t(out_t),
    .out_valid(out_valid), .out_ready(out_ready), .err_chksum(err_chksum),
    .err_target(err_target), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: position in frame plus a buffer of the five payload bytes.
  int         m_pos = 0;
  logic [7:0] fr [5];
  logic       m_hold = 1'b0;
  logic [7:0] m_out [5];
  logic       m_vld = 1'b0, m_ec = 1'b0, m_et = 1'b0;
  logic [7:0] m_cnt = 8'h00;
  logic       last_acc;
  logic       r_rdy;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic ordy);
    logic [7:0] sum;
    m_ec = 1'b0;
    m_et = 1'b0;
    if (r) begin
      m_pos = 0; m_hold = 1'b0; m_vld = 1'b0; m_cnt = 8'h00;
      for (int i = 0; i < 5; i++) m_out[i] = 8'h00;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0; m_vld = 1'b0; m_cnt = m_cnt + 8'd1;
      end
    end else if (v) begin
      if (m_pos == 0) begin
        if (d == 8'hA5) m_pos = 1;
      end else if (m_pos == 1) begin
        if (d > 8'd31) begin m_et = 1'b1; m_pos = 0; end
        else begin fr[0] = d; m_pos = 2; end
      end else if (m_pos < 6) begin
        fr[m_pos-1] = d; m_pos++;
      end else begin
        sum = fr[0] ^ fr[1] ^ fr[2] ^ fr[3] ^ fr[4];
        if (d == sum) begin
          for (int i = 0; i < 5; i++) m_out[i] = fr[i];
          m_vld = 1'b1; m_hold = 1'b1;
        end else m_ec = 1'b1;
        m_pos = 0;
      end
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    r_rdy = !r && !m_hold;
    chk("in_ready", {7'd0, in_ready}, {7'd0, r_rdy});
    last_acc = r_rdy && v;
    @(posedge clk);
    model_step(r, v, d, ordy);
    #1;
    chk("out_valid", {7'd0, out_valid}, {7'd0, m_vld});
    chk("out_target", {3'd0, out_target}, m_out[0]);
    chk("out_x", out_x, m_out[1]);
    chk("out_y", out_y, m_out[2]);
    chk("out_z", out_z, m_out[3]);
    chk("out_t", out_t, m_out[4]);
    chk("err_chksum", {7'd0, err_chksum}, {7'd0, m_ec});
    chk("err_target", {7'd0, err_target}, {7'd0, m_et});
    chk("frame_count", frame_count, m_cnt);
  endtask

  // Offer one byte until the model says it was taken; rnd selects random out_ready/gaps.
  task automatic send_byte(input logic [7:0] d, input bit rnd);
    int tries = 0;
    last_acc = 1'b0;
    while (!last_acc && tries < 200) begin
      if (rnd && $urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 8'($urandom), 1'($urandom));
      else tick(1'b0, 1'b1, d, rnd ? 1'($urandom) : 1'b1);
      tries++;
    end
    if (!last_acc) begin
      total++; bad++;
      $error("FAIL send_timeout observed=%0d expected<200", tries);
    end
  endtask

  task automatic send_frame(input logic [7:0] t, x, y, z, tm, input bit bad_chk, input bit rnd);
    logic [7:0] c;
    c = t ^ x ^ y ^ z ^ tm;
    if (bad_chk) c = c ^ 8'(1 << $urandom_range(0, 7));
    send_byte(8'hA5, rnd); send_byte(t, rnd); send_byte(x, rnd); send_byte(y, rnd);
    send_byte(z, rnd); send_byte(tm, rnd); send_byte(c, rnd);
  endtask

  initial begin
    repeat (3) tick(1'b1, 1'b1, 8'hA5, 1'b1);
    chk("reset_count", frame_count, 8'h00);

    // Basic frame, out_ready high.
    send_frame(8'h03, 8'h10, 8'h20, 8'h30, 8'h01, 1'b0, 1'b0);
    chk("f1_valid", {7'd0, out_valid}, 8'h01);
    chk("f1_target", {3'd0, out_target}, 8'h03);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("f1_count", frame_count, 8'h01);

    // Corrupted checksum, then a good frame.
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h10, 0); send_byte(8'h20, 0);
    send_byte(8'h30, 0); send_byte(8'h01, 0); send_byte(8'h07, 0);
    chk("bad_chk_pulse", {7'd0, err_chksum}, 8'h01);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bad_chk_once", {7'd0, err_chksum}, 8'h00);
    send_frame(8'h1F, 8'hA5, 8'hA5, 8'h00, 8'hFF, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("after_bad_count", frame_count, 8'h02);

    // Junk then illegal target.
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'hA5, 0); send_byte(8'h28, 0);
    chk("bad_tgt_pulse", {7'd0, err_target}, 8'h01);

    // Backpressure: hold with data offered for 10 cycles.
    send_frame(8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
    chk("hold_x", out_x, 8'h11);
    tick(1'b0, 1'b1, 8'hA5, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset after X byte, then a complete frame.
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h55, 0);
    tick(1'b1, 1'b1, 8'h66, 1'b0);
    send_byte(8'h77, 0); send_byte(8'h88, 0);
    send_frame(8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0);
    chk("post_rst_z", out_z, 8'h03);
    tick(1'b0, 1'b0, 8'h00, 1'b1);

    // 256 back-to-back frames wrap the counter.
    for (int i = 0; i < 256; i++) begin
      send_frame(8'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 1'b0, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("wrap_count", frame_count, 8'h01);

    // Randomized mix of good, bad and junk traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: send_frame(8'($urandom_range(0, 31)), 8'($urandom), 8'($urandom),
                                     8'($urandom), 8'($urandom), 1'b0, 1'b1);
        6: send_frame(8'($urandom_range(0, 31)), 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), 1'b1, 1'b1);
        7: begin send_byte(8'hA5, 1); send_byte(8'($urandom_range(32, 255)), 1); end
        8: repeat ($urandom_range(1, 4)) send_byte(8'($urandom), 1);
        default: tick(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
      endcase
    end
    repeat (4) tick(1'b0, 1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/telemetry_frame_rx.md
TELEMETRY_FRAME_RX -- requirements
Module: telemetry_frame_rx

Interface
REQ-001 Parameter SYNC, default 8'hA5: frame start byte.
REQ-002 Parameter MAX_TGT, default 31: highest legal target index.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  incoming telemetry byte.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a byte this cycle; transfer occurs when in_valid && in_ready.
REQ-008 out_target  output  5  decoded target index, fed to the coordinate-register decoder.
REQ-009 out_x, out_y, out_z, out_t  output  8 each  assembled coordinate and time bytes.
REQ-010 out_valid  output  1  a complete, checked frame is presented.
REQ-011 out_ready  input  1  downstream load accepted; handshake completes when out_valid && out_ready.
REQ-012 err_chksum  output  1  one-cycle pulse: frame dropped on checksum mismatch.
REQ-013 err_target  output  1  one-cycle pulse: frame dropped because the target byte is > MAX_TGT.
REQ-014 frame_count  output  8  count of completed output handshakes.

Function
REQ-015 The frame format SHALL be 7 bytes in order: SYNC, TGT, X, Y, Z, T, CHK.
REQ-016 CHK SHALL equal the 8-bit XOR of TGT, X, Y, Z and T.
REQ-017 The FSM states SHALL be IDLE, TGT, X, Y, Z, T, CHK and HOLD, and each state advances only on an accepted byte, except HOLD.
REQ-018 In IDLE, an accepted byte equal to SYNC SHALL move the FSM to TGT; any other byte SHALL be discarded with no other effect.
REQ-019 In TGT, a byte > MAX_TGT SHALL pulse err_target on the following cycle and return the FSM to IDLE; otherwise the byte is latched and the FSM moves to X.
REQ-020 A byte equal to SYNC inside a frame (TGT..CHK) SHALL be treated as data, with no resynchronisation.
REQ-021 The running XOR SHALL clear on SYNC acceptance and SHALL fold in each accepted TGT, X, Y, Z and T byte.
REQ-022 In CHK, on a match the FSM SHALL move to HOLD and out_valid SHALL rise on the cycle after the CHK byte is accepted, for a latency of 1 cycle.
REQ-023 In CHK, on a mismatch err_chksum SHALL pulse for exactly 1 cycle, the FSM SHALL return to IDLE, and out_valid and out_* SHALL remain unchanged.
REQ-024 in_ready SHALL be 1 in every state except HOLD, where it is 0; in_valid in HOLD SHALL have no effect.
REQ-025 out_target and out_x..out_t SHALL be stable while out_valid=1 and update only when a new frame enters HOLD.
REQ-026 On out_valid && out_ready, out_valid SHALL drop the next cycle, the FSM SHALL go to IDLE, and frame_count SHALL increment, wrapping from 255 to 0.
REQ-027 out_valid SHALL hold indefinitely while out_ready=0.
REQ-028 out_ready asserted while out_valid=0 SHALL be ignored.
REQ-029 err_chksum and err_target SHALL never be asserted in the same cycle.

Reset
REQ-030 While rst=1: FSM in IDLE; in_ready=0; out_valid=0; err_chksum=0; err_target=0; out_target, out_x..out_t, the running XOR and frame_count all 0.
REQ-031 From the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-032 Reset mid-frame or in HOLD SHALL discard the partial or pending frame, and the next frame SHALL require a fresh SYNC.

Verification
REQ-033 Bytes A5,03,10,20,30,01,02 with out_ready=1 -> out_valid high 1 cycle after CHK; out_target=3, x=10, y=20, z=30, t=01; frame_count=1.
REQ-034 Same frame but CHK=0x07 -> err_chksum pulses 1 cycle, out_valid stays 0, frame_count unchanged; a following valid frame is accepted normally.
REQ-035 Bytes 00,FF,A5,28,... -> leading 00 and FF are ignored; TGT 0x28 > 31 pulses err_target; FSM returns to IDLE.
REQ-036 Valid frame with out_ready=0 for 10 cycles while in_valid=1 with data -> out_valid and out_* stable, in_ready=0 throughout; after out_ready=1, frame_count increments and in_ready returns to 1.
REQ-037 rst asserted after the X byte, then a full valid frame -> no output from the partial frame; the new frame is delivered correctly.
REQ-038 256 back-to-back valid frames -> frame_count wraps to 0.
